// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// A start/ready/done handshake frames each operation.
//
// state | meaning
// IDLE  | ready for a new operation, outputs hold the last result
// RUN   | one restoring step per edge, DIVIDEND_W steps in total
// DONE  | single-cycle done pulse, then back to IDLE
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ready,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
    logic [DIVIDEND_W-1:0] q_sh;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVISOR_W:0]    prem;

    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    diff;
    logic                  fits;
    logic [DIVISOR_W:0]    prem_next;
    logic [DIVIDEND_W-1:0] q_next;

    always_comb begin
        shifted   = {prem[DIVISOR_W-1:0], q_sh[DIVIDEND_W-1]};
        diff      = shifted - {1'b0, dsr};
        fits      = (shifted >= {1'b0, dsr});
        prem_next = fits ? diff : shifted;
        q_next    = {q_sh[DIVIDEND_W-2:0], fits};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            q_sh        <= '0;
            dsr         <= '0;
            prem        <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ready <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q_sh        <= dividend;
                            dsr         <= divisor;
                            prem        <= '0;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    q_sh <= q_next;
                    prem <= prem_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        quotient  <= q_next;
                        remainder <= prem_next[DIVISOR_W-1:0];
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider; the inverse operation of the team's combinational 4x4 multiplier.
- Takes a DIVIDEND_W-bit dividend and a DIVISOR_W-bit divisor and produces quotient and remainder.
- Resolves one quotient bit per clock.
- Used by the datapath wherever a product must be undone (e.g. checking res / b == a); a start/ready/done handshake frames each operation.

Parameters:
DIVIDEND_W, 8, dividend and quotient width (>= DIVISOR_W)
DIVISOR_W, 4, divisor and remainder width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; accepted only on a rising edge where ready=1
dividend  input  DIVIDEND_W  numerator, sampled on the accept edge
divisor  input  DIVISOR_W  denominator, sampled on the accept edge
ready  output  1  high only in IDLE
done  output  1  single-cycle pulse; results valid from this cycle on
quotient  output  DIVIDEND_W  result quotient
remainder  output  DIVISOR_W  result remainder
div_by_zero  output  1  set when the accepted divisor was 0

Behaviour:
- Reset (async, rst=1): state=IDLE, step counter=0, all internal registers=0, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0. Any in-flight operation is discarded.
- States and transitions:
  - IDLE: ready=1. On start=1 with divisor!=0: latch operands, clear partial remainder (DIVISOR_W+1 bits), clear counter, clear div_by_zero, go to RUN. On start=1 with divisor==0: quotient=all ones, remainder=0, div_by_zero=1, go to DONE.
  - RUN: ready=0. Each edge performs one restoring step:
    - shift the next dividend MSB into the partial remainder;
    - trial-subtract the divisor (zero-extended to DIVISOR_W+1);
    - if the result is non-negative, keep it and shift a 1 into the quotient; otherwise restore and shift a 0.
    - The counter increments each step. After step DIVIDEND_W, load the quotient/remainder outputs and go to DONE.
  - DONE: done=1 for exactly one cycle, ready=0. Next edge returns to IDLE unconditionally.
- Latency, counted from the accept edge:
  - Normal operation: done is high in the cycle following the DIVIDEND_W-th edge after accept (8 cycles at defaults).
  - Divide-by-zero: done is high in the cycle immediately after the accept edge.
- Holding and ignored inputs:
  - quotient, remainder and div_by_zero hold their values after done until the next accepted start, which also clears div_by_zero.
  - start while ready=0 (RUN or DONE) is ignored; it is not queued.
  - Operand inputs may change freely after the accept edge without affecting the result.
- Arithmetic: quotient = floor(dividend/divisor), remainder = dividend mod divisor. The remainder is always < divisor and fits in DIVISOR_W bits; the internal partial remainder needs DIVISOR_W+1 bits to hold the pre-subtract shift.
- Back-to-back: start held high continuously gives one accept every DIVIDEND_W+2 cycles (accept, DIVIDEND_W RUN cycles, DONE, and back in IDLE).
- Reset asserted during RUN or DONE: immediate return to IDLE with cleared outputs; no done pulse is produced.

Test Plan:
- 200 / 7 -> done exactly 8 cycles after the accept edge; quotient=28, remainder=4, div_by_zero=0; ready returns to 1 the next cycle.
- Corner operands:
  - 255 / 15 -> quotient=17, remainder=0.
  - 5 / 9 -> quotient=0, remainder=5.
  - 255 / 1 -> quotient=255, remainder=0.
- 100 / 0 -> done 1 cycle after accept; quotient=8'hFF, remainder=0, div_by_zero=1. A following 12 / 3 clears the flag and gives quotient=4, remainder=0.
- Change dividend/divisor and pulse start during RUN -> result still matches the originally latched operands; no second done pulse.
- Assert rst mid-RUN (cycle 4) -> outputs zero immediately, ready=1, no done pulse. A new 81 / 9 then gives quotient=9, remainder=0.
- Exhaustive sweep of all 256x16 operand pairs -> every result matches floor and mod. For every nonzero divisor, the multiplier product of quotient[3:0] x divisor plus remainder equals the dividend whenever quotient < 16.
